// File: rtl/tagged_multi_fifo_pkg.sv
// ----------------------------------------------------------------------------
// tagged_multi_fifo_pkg
// Shared definitions for the tagged multi-channel FIFO slice.
//   RST_ACT  : level of the asynchronous reset input that clears the design
//   tmfClog2 : elaboration-time ceiling log2, used to size tags, pointers
//              and occupancy counters from the DEPTH/NCH parameters
// No ports; imported by tagged_multi_fifo and tagged_multi_fifo_channel.
// ----------------------------------------------------------------------------
package tagged_multi_fifo_pkg;

    // The reset input is active-low: everything clears while it reads 0.
    localparam logic RST_ACT = 1'b0;

    // Smallest n with 2**n >= value. Callers only pass powers of two >= 2,
    // so this is an exact log2 for every legal configuration.
    function automatic int tmfClog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tagged_multi_fifo_channel.sv
// ----------------------------------------------------------------------------
// tagged_multi_fifo_channel
// One independent circular buffer of DEPTH words for the tagged FIFO.
// Ports:
//   ck          in   clock, rising edge
//   rst         in   asynchronous reset, active-low
//   push        in   store din at the write pointer this edge
//   pop         in   retire the head word this edge
//   din         in   word to store
//   dout        out  current head word (combinational read of the array)
//   full        out  count == DEPTH
//   empty       out  count == 0
//   almost_full out  count >= AF_LVL
//   count       out  current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module tagged_multi_fifo_channel
    import tagged_multi_fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    parameter  int AF_LVL = 6,
    localparam int AW     = tmfClog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_doPush;
    logic w_doPop;

    // A pop only happens when there is something to retire. A push into a
    // full buffer is legal only when the head is leaving on the same edge;
    // with wptr == rptr the new word lands in the slot being read out, and
    // the old head has already been captured through dout on this edge.
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    // Pointers wrap naturally because DEPTH is a power of two. The counter
    // moves only when exactly one of push/pop happens.
    always_ff @(posedge ck or negedge rst) begin
        if (rst == RST_ACT) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array has no reset: stale contents are unreachable once the
    // pointers and counter are cleared.
    always_ff @(posedge ck) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= din;
        end
    end

    assign dout        = r_mem[r_rptr];
    assign count       = r_count;
    assign full        = (r_count == CNT_W'(DEPTH));
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= CNT_W'(AF_LVL));

endmodule

// File: rtl/tagged_multi_fifo.sv
// ----------------------------------------------------------------------------
// tagged_multi_fifo
// Multi-channel tagged FIFO. The top CH_W bits of each written word pick the
// destination channel; consumers pop per channel with a one-hot read vector.
// Ports:
//   ck          in   clock, rising edge
//   rst         in   asynchronous reset, active-low
//   wr          in   write strobe, datain goes to channel datain[DATA_W-1 -: CH_W]
//   datain      in   word to write (tag bits included, stored unmodified)
//   rd          in   pop request, bit i = channel i; lowest set bit is served
//   dataout     out  registered popped word, held when nothing pops
//   dout_valid  out  one-cycle pulse, dataout was updated on the last edge
//   full        out  per-channel full flags
//   empty       out  per-channel empty flags
//   almost_full out  per-channel count >= AF_LVL
//   count       out  per-channel occupancy, channel i at [i*CNT_W +: CNT_W]
//   drop_cnt    out  saturating count of writes rejected by a full channel
//   rd_err      out  one-cycle pulse for multi-bit or underflowing reads
// ----------------------------------------------------------------------------
module tagged_multi_fifo
    import tagged_multi_fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NCH    = 2,
    parameter  int DEPTH  = 8,
    parameter  int AF_LVL = 6,
    parameter  int DROP_W = 8,
    localparam int CH_W   = tmfClog2(NCH),
    localparam int CNT_W  = tmfClog2(DEPTH) + 1
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [DATA_W-1:0]    datain,
    input  logic [NCH-1:0]       rd,
    output logic [DATA_W-1:0]    dataout,
    output logic                 dout_valid,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       almost_full,
    output logic [NCH*CNT_W-1:0] count,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic                 rd_err
);

    logic [CH_W-1:0]   w_tag;
    logic [CH_W-1:0]   w_rdIdx;
    logic              w_rdAny;
    logic              w_rdMulti;
    logic [NCH-1:0]    w_push;
    logic [NCH-1:0]    w_pop;
    logic              w_popAny;
    logic              w_drop;
    logic              w_rdErrNext;
    logic [DATA_W-1:0] w_head [NCH];
    logic [DATA_W-1:0] w_servedWord;

    logic [DATA_W-1:0] r_dataout;
    logic              r_doutValid;
    logic              r_rdErr;
    logic [DROP_W-1:0] r_dropCnt;

    assign w_tag = datain[DATA_W-1 -: CH_W];

    // Priority encoder: scanning from the top down leaves the lowest set
    // bit of rd as the selected channel.
    always_comb begin
        w_rdIdx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rd[i]) begin
                w_rdIdx = CH_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more
    // request bits were set.
    assign w_rdAny   = |rd;
    assign w_rdMulti = |(rd & (rd - NCH'(1)));

    // A write is dropped only when its channel is full and that channel is
    // not popping on the same edge.
    assign w_popAny     = |w_pop;
    assign w_drop       = wr && full[w_tag] && !w_pop[w_tag];
    assign w_rdErrNext  = w_rdMulti || (w_rdAny && empty[w_rdIdx]);
    assign w_servedWord = w_head[w_rdIdx];

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : gChan
            assign w_pop[g]  = w_rdAny && (w_rdIdx == CH_W'(g)) && !empty[g];
            assign w_push[g] = wr && (w_tag == CH_W'(g)) && (!full[g] || w_pop[g]);

            tagged_multi_fifo_channel #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .AF_LVL (AF_LVL)
            ) uChannel (
                .ck          (ck),
                .rst         (rst),
                .push        (w_push[g]),
                .pop         (w_pop[g]),
                .din         (datain),
                .dout        (w_head[g]),
                .full        (full[g]),
                .empty       (empty[g]),
                .almost_full (almost_full[g]),
                .count       (count[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Output stage: capture the served head word, the valid pulse and the
    // read-error pulse; keep the saturating drop counter.
    always_ff @(posedge ck or negedge rst) begin
        if (rst == RST_ACT) begin
            r_dataout   <= '0;
            r_doutValid <= 1'b0;
            r_rdErr     <= 1'b0;
            r_dropCnt   <= '0;
        end else begin
            if (w_popAny) begin
                r_dataout <= w_servedWord;
            end
            r_doutValid <= w_popAny;
            r_rdErr     <= w_rdErrNext;
            if (w_drop && (r_dropCnt != '1)) begin
                r_dropCnt <= r_dropCnt + DROP_W'(1);
            end
        end
    end

    assign dataout    = r_dataout;
    assign dout_valid = r_doutValid;
    assign rd_err     = r_rdErr;
    assign drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_tagged_multi_fifo.sv
// ----------------------------------------------------------------------------
// tb_tagged_multi_fifo
// Directed bench for tagged_multi_fifo (DATA_W=8, NCH=2, DEPTH=8, AF_LVL=6).
// A queue-per-channel model tracks the expected outputs and is compared with
// the DUT on every falling edge; directed steps add literal expectations.
// ----------------------------------------------------------------------------
module tb_tagged_multi_fifo;

    localparam int DATA_W   = 8;
    localparam int NCH      = 2;
    localparam int DEPTH    = 8;
    localparam int AF_LVL   = 6;
    localparam int DROP_W   = 8;
    localparam int CH_W     = $clog2(NCH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                 ck = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr = 1'b0;
    logic [DATA_W-1:0]    datain = '0;
    logic [NCH-1:0]       rd = '0;
    logic [DATA_W-1:0]    dataout;
    logic                 dout_valid;
    logic [NCH-1:0]       full;
    logic [NCH-1:0]       empty;
    logic [NCH-1:0]       almost_full;
    logic [NCH*CNT_W-1:0] count;
    logic [DROP_W-1:0]    drop_cnt;
    logic                 rd_err;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    always #5 ck = ~ck;

    tagged_multi_fifo #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .DROP_W (DROP_W)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .wr          (wr),
        .datain      (datain),
        .rd          (rd),
        .dataout     (dataout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .drop_cnt    (drop_cnt),
        .rd_err      (rd_err)
    );

    // Single place where a comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, let the rising edge
    // sample them, return on the next falling edge with inputs idled.
    task automatic applyStimulus(input logic w, input logic [DATA_W-1:0] d,
                                 input logic [NCH-1:0] r);
        wr     = w;
        datain = d;
        rd     = r;
        @(posedge ck);
        @(negedge ck);
        wr = 1'b0;
        rd = '0;
    endtask

    // Behavioural model: each channel is a plain queue of words.
    logic [DATA_W-1:0] mQ [NCH][$];
    int                mDrop;
    logic [DATA_W-1:0] mDout;
    logic              mValid;
    logic              mErr;
    int                mTag;
    int                mIdx;
    logic              mAny;
    logic              mPopOk;

    // Model update: serve the lowest requested channel from its queue, then
    // accept the write if the target queue has room after that pop.
    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) mQ[c].delete();
            mDrop  = 0;
            mDout  = '0;
            mValid = 1'b0;
            mErr   = 1'b0;
        end else begin
            mTag = int'(datain[DATA_W-1 -: CH_W]);
            mAny = (rd != '0);
            mIdx = 0;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (rd[c]) mIdx = c;
            end
            mPopOk = mAny && (mQ[mIdx].size() > 0);
            if (mPopOk) mDout = mQ[mIdx].pop_front();
            mValid = mPopOk;
            mErr   = ($countones(rd) > 1) || (mAny && !mPopOk);
            if (wr) begin
                if (mQ[mTag].size() < DEPTH) mQ[mTag].push_back(datain);
                else if (mDrop < DROP_MAX) mDrop++;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge ck) begin
        if (checkEn) begin
            checkOutput("dataout", dataout, mDout);
            checkOutput("dout_valid", dout_valid, mValid);
            checkOutput("rd_err", rd_err, mErr);
            checkOutput("drop_cnt", drop_cnt, mDrop);
            for (int c = 0; c < NCH; c++) begin
                checkOutput($sformatf("count[%0d]", c), count[c*CNT_W +: CNT_W], mQ[c].size());
                checkOutput($sformatf("full[%0d]", c), full[c], mQ[c].size() == DEPTH);
                checkOutput($sformatf("empty[%0d]", c), empty[c], mQ[c].size() == 0);
                checkOutput($sformatf("almost_full[%0d]", c), almost_full[c], mQ[c].size() >= AF_LVL);
            end
        end
    end

    // Directed sequence with literal expectations.
    initial begin
        // Power-up reset, asserted and released away from clock edges.
        #2 rst = 1'b0;
        checkEn = 1'b1;
        #1;
        checkOutput("reset empty", empty, 2'b11);
        checkOutput("reset count", count, 8'h00);
        checkOutput("reset dataout", dataout, 8'h00);
        @(negedge ck);
        #2 rst = 1'b1;
        @(negedge ck);

        // Basic tag routing and in-order pops.
        applyStimulus(1'b1, 8'h81, 2'b00);
        applyStimulus(1'b1, 8'h82, 2'b00);
        applyStimulus(1'b1, 8'h01, 2'b00);
        checkOutput("t1 count ch1", count[7:4], 4'd2);
        checkOutput("t1 count ch0", count[3:0], 4'd1);
        checkOutput("t1 empty", empty, 2'b00);
        applyStimulus(1'b0, 8'h00, 2'b10);
        checkOutput("t1 pop1 data", dataout, 8'h81);
        checkOutput("t1 pop1 valid", dout_valid, 1'b1);
        applyStimulus(1'b0, 8'h00, 2'b10);
        checkOutput("t1 pop2 data", dataout, 8'h82);
        applyStimulus(1'b0, 8'h00, 2'b01);
        checkOutput("t1 pop3 data", dataout, 8'h01);

        // Fill ch1 past capacity, then drain through the pointer wrap.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 8'h80 + 8'(k), 2'b00);
            if (k == 4) checkOutput("t2 af after 5", almost_full, 2'b00);
            if (k == 5) checkOutput("t2 af after 6", almost_full, 2'b10);
            if (k == 6) checkOutput("t2 full after 7", full, 2'b00);
            if (k == 7) checkOutput("t2 full after 8", full, 2'b10);
        end
        checkOutput("t2 drop", drop_cnt, 8'd1);
        checkOutput("t2 count ch1", count[7:4], 4'd8);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 8'h00, 2'b10);
            checkOutput($sformatf("t2 pop %0d", k), dataout, 8'h80 + 8'(k));
        end
        checkOutput("t2 empty", empty, 2'b11);

        // Write and pop a full channel on the same edge.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'h90 + 8'(k), 2'b00);
        applyStimulus(1'b1, 8'h8F, 2'b10);
        checkOutput("t3 data", dataout, 8'h90);
        checkOutput("t3 count ch1", count[7:4], 4'd8);
        checkOutput("t3 drop", drop_cnt, 8'd1);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 8'h00, 2'b10);
            checkOutput($sformatf("t3 pop %0d", k), dataout, 8'h90 + 8'(k));
        end
        applyStimulus(1'b0, 8'h00, 2'b10);
        checkOutput("t3 last pop", dataout, 8'h8F);

        // Multi-bit read, underflow, and write+pop on an empty channel.
        applyStimulus(1'b1, 8'h01, 2'b00);
        applyStimulus(1'b1, 8'h02, 2'b00);
        applyStimulus(1'b1, 8'h83, 2'b00);
        applyStimulus(1'b0, 8'h00, 2'b11);
        checkOutput("t4 multi data", dataout, 8'h01);
        checkOutput("t4 multi err", rd_err, 1'b1);
        checkOutput("t4 multi ch1 kept", count[7:4], 4'd1);
        applyStimulus(1'b0, 8'h00, 2'b00);
        checkOutput("t4 idle err", rd_err, 1'b0);
        checkOutput("t4 idle valid", dout_valid, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b01);
        checkOutput("t4 pop ch0", dataout, 8'h02);
        applyStimulus(1'b0, 8'h00, 2'b01);
        checkOutput("t4 underflow err", rd_err, 1'b1);
        checkOutput("t4 underflow data", dataout, 8'h02);
        checkOutput("t4 underflow valid", dout_valid, 1'b0);
        applyStimulus(1'b1, 8'h05, 2'b01);
        checkOutput("t4 wr+rd empty err", rd_err, 1'b1);
        checkOutput("t4 wr+rd empty count", count[3:0], 4'd1);
        applyStimulus(1'b0, 8'h00, 2'b01);
        checkOutput("t4 no bypass word", dataout, 8'h05);
        applyStimulus(1'b0, 8'h00, 2'b10);
        checkOutput("t4 ch1 word", dataout, 8'h83);

        // Saturate the drop counter against a full ch0.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'h00 + 8'(k), 2'b00);
        for (int k = 0; k < 300; k++) applyStimulus(1'b1, 8'h10, 2'b00);
        checkOutput("t5 drop sat", drop_cnt, 8'hFF);
        checkOutput("t5 full", full, 2'b01);

        // Mid-stream asynchronous reset, 3 ns long, away from clock edges.
        applyStimulus(1'b0, 8'h00, 2'b01);
        #1 rst = 1'b0;
        #2;
        checkOutput("t6 dataout", dataout, 8'h00);
        checkOutput("t6 valid", dout_valid, 1'b0);
        checkOutput("t6 drop", drop_cnt, 8'h00);
        checkOutput("t6 empty", empty, 2'b11);
        checkOutput("t6 full", full, 2'b00);
        checkOutput("t6 af", almost_full, 2'b00);
        checkOutput("t6 count", count, 8'h00);
        checkOutput("t6 rd_err", rd_err, 1'b0);
        #1 rst = 1'b1;
        @(negedge ck);
        applyStimulus(1'b1, 8'h81, 2'b00);
        checkOutput("t6 post count ch1", count[7:4], 4'd1);
        applyStimulus(1'b0, 8'h00, 2'b10);
        checkOutput("t6 post data", dataout, 8'h81);
        checkOutput("t6 post valid", dout_valid, 1'b1);
        applyStimulus(1'b0, 8'h00, 2'b00);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
